// File: rtl/pwm_duty_decoder.sv
// PWM receive end: measures high-time over each 2^WIDTH-tick period and
// reports the recovered duty word with a one-cycle VALID strobe.
module pwm_duty_decoder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             PWM_IN,
  output logic [WIDTH-1:0] D_OUT,
  output logic             VALID,
  output logic             PERIOD_ERR,
  output logic             STUCK
);

  localparam logic [WIDTH:0]   FULL = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0]   ONE  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAXD = {WIDTH{1'b1}};

  typedef enum logic {SEEK, MEASURE} state_t;

  state_t         r_state;
  logic           r_sync1;
  logic           r_sync2;
  logic           r_p;
  logic [WIDTH:0] r_period_cnt;
  logic [WIDTH:0] r_high_cnt;

  logic             w_rise;
  logic             w_timeout;
  logic [WIDTH:0]   w_period_inc;
  logic [WIDTH:0]   w_high_inc;
  logic [WIDTH-1:0] w_d_sat;

  assign w_rise       = r_sync2 & ~r_p;
  assign w_timeout    = (r_period_cnt == FULL);
  assign w_period_inc = w_timeout ? r_period_cnt : r_period_cnt + ONE;
  assign w_high_inc   = (r_sync2 && (r_high_cnt != FULL)) ? r_high_cnt + ONE : r_high_cnt;
  // high_cnt never exceeds FULL, so only that one value needs clamping
  assign w_d_sat      = (r_high_cnt == FULL) ? MAXD : r_high_cnt[WIDTH-1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= SEEK;
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_p          <= 1'b0;
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      D_OUT        <= '0;
      VALID        <= 1'b0;
      PERIOD_ERR   <= 1'b0;
      STUCK        <= 1'b0;
    end else begin
      r_sync1 <= PWM_IN;
      r_sync2 <= r_sync1;
      VALID   <= 1'b0;
      if (CE) begin
        r_p <= r_sync2;
        // a rising edge always wins over timeout on the same tick
        if (w_rise) begin
          r_state      <= MEASURE;
          r_period_cnt <= ONE;
          r_high_cnt   <= ONE;
          STUCK        <= 1'b0;
          if (r_state == MEASURE) begin
            VALID      <= 1'b1;
            D_OUT      <= w_d_sat;
            PERIOD_ERR <= (r_period_cnt != FULL);
          end
        end else if (w_timeout) begin
          r_state      <= SEEK;
          r_period_cnt <= ONE;
          r_high_cnt   <= ONE;
          VALID        <= 1'b1;
          D_OUT        <= r_sync2 ? MAXD : '0;
          STUCK        <= 1'b1;
          PERIOD_ERR   <= 1'b0;
        end else begin
          r_period_cnt <= w_period_inc;
          r_high_cnt   <= w_high_inc;
        end
      end
    end
  end

endmodule
